kim_fifo_flex: RTL and testbench

Parametrised valid/ready FIFO: next generation of the team's control+mem FIFO, with generic width and depth, an output skid register for full-throughput first-word-fall-through, a fill-level counter, programmable almost-full/almost-empty flags and a synchronous flush. It sits between streaming producers and consumers in the datapath and drops in wherever the fixed 4-deep FIFO is used today.

---
 rtl/kim_fifo_pkg.sv | 18 +
 rtl/kim_fifo_flex_if.sv | 11 +
 rtl/kim_fifo_flex_mem.sv | 24 ++
 rtl/kim_fifo_flex.sv | 114 +++++++++++
 tb/tb_kim_fifo_flex.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/kim_fifo_pkg.sv
// Shared FIFO helpers: level-counter sizing and threshold checks.
// Later FIFO variants reuse this package.
package kim_fifo_pkg;

  // Level counter must hold 0..DEPTH+1 for a power-of-two DEPTH.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic lvl_at_or_above(input int lvl, input int thresh);
    return (lvl >= thresh);
  endfunction

  function automatic logic lvl_at_or_below(input int lvl, input int thresh);
    return (lvl <= thresh);
  endfunction

endpackage

// File: rtl/kim_fifo_flex_if.sv
// Valid/ready streaming bus; master drives valid/data, slave drives ready.
interface kim_fifo_flex_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/kim_fifo_flex_mem.sv
// Simple dual-port register array: synchronous write, combinational read.
// The data array is deliberately not reset.
module kim_fifo_flex_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  i_w_en,
  input  logic [LOG2_DEPTH-1:0] i_w_addr,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic [LOG2_DEPTH-1:0] i_r_addr,
  output logic [DATA_WIDTH-1:0] o_r_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_w_en) r_mem[i_w_addr] <= i_w_data;
  end

  assign o_r_data = r_mem[i_r_addr];

endmodule

// File: rtl/kim_fifo_flex.sv
// Valid/ready FIFO with output skid register (first-word-fall-through),
// fill level, registered almost-full/almost-empty flags and synchronous flush.
module kim_fifo_flex
  import kim_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4,
  parameter int LOG2_DEPTH    = 2,
  parameter int AFULL_THRESH  = DEPTH,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  kim_fifo_flex_if.slave      s_if,
  kim_fifo_flex_if.master     m_if,
  output logic [LOG2_DEPTH:0] level,
  output logic                almost_full,
  output logic                almost_empty
);

  localparam int PTR_W = LOG2_DEPTH + 1;

  // Pointers carry a wrap bit above the address bits.
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [PTR_W-1:0]      r_level;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_afull;
  logic                  r_aempty;

  logic [PTR_W-1:0]      w_mem_count;
  logic                  w_mem_empty;
  logic                  w_s_ready;
  logic                  w_accept;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_wr_en;
  logic                  w_refill;
  logic [PTR_W-1:0]      w_level_next;
  logic [DATA_WIDTH-1:0] w_mem_rdata;

  assign w_mem_count = r_wptr - r_rptr;
  assign w_mem_empty = (r_wptr == r_rptr);
  assign w_s_ready   = !flush && (w_mem_count != PTR_W'(DEPTH));
  assign w_accept    = s_if.valid && w_s_ready;
  assign w_pop       = r_out_valid && m_if.ready;
  assign w_bypass    = w_accept && w_mem_empty && (!r_out_valid || w_pop);
  assign w_wr_en     = w_accept && !w_bypass;
  assign w_refill    = w_pop && !w_mem_empty;

  always_comb begin
    w_level_next = r_level;
    if (flush)                  w_level_next = '0;
    else if (w_accept && !w_pop) w_level_next = r_level + PTR_W'(1);
    else if (w_pop && !w_accept) w_level_next = r_level - PTR_W'(1);
  end

  kim_fifo_flex_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_mem (
    .clk      (clk),
    .i_w_en   (w_wr_en),
    .i_w_addr (r_wptr[LOG2_DEPTH-1:0]),
    .i_w_data (s_if.data),
    .i_r_addr (r_rptr[LOG2_DEPTH-1:0]),
    .o_r_data (w_mem_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_afull     <= 1'b0;
      r_aempty    <= lvl_at_or_below(0, AEMPTY_THRESH);
    end else begin
      r_level  <= w_level_next;
      r_afull  <= lvl_at_or_above(int'(w_level_next), AFULL_THRESH);
      r_aempty <= lvl_at_or_below(int'(w_level_next), AEMPTY_THRESH);
      if (flush) begin
        // A pop in this cycle has already been delivered; just discard state.
        r_wptr      <= '0;
        r_rptr      <= '0;
        r_out_valid <= 1'b0;
      end else begin
        if (w_wr_en)  r_wptr <= r_wptr + PTR_W'(1);
        if (w_refill) r_rptr <= r_rptr + PTR_W'(1);
        if (w_bypass) begin
          r_out_valid <= 1'b1;
          r_out_data  <= s_if.data;
        end else if (w_refill) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_mem_rdata;
        end else if (w_pop) begin
          r_out_valid <= 1'b0;
        end
      end
    end
  end

  assign s_if.ready   = w_s_ready;
  assign m_if.valid   = r_out_valid;
  assign m_if.data    = r_out_data;
  assign level        = r_level;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;

endmodule

// File: tb/tb_kim_fifo_flex.sv
// Directed and randomised checks of kim_fifo_flex with DEPTH=4.
module tb_kim_fifo_flex;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic [2:0] level;
  logic       afull;
  logic       aempty;

  kim_fifo_flex_if #(.DATA_WIDTH(DW)) s_bus ();
  kim_fifo_flex_if #(.DATA_WIDTH(DW)) m_bus ();

  kim_fifo_flex #(
    .DATA_WIDTH    (DW),
    .DEPTH         (DEPTH),
    .LOG2_DEPTH    (2),
    .AFULL_THRESH  (DEPTH),
    .AEMPTY_THRESH (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .s_if         (s_bus),
    .m_if         (m_bus),
    .level        (level),
    .almost_full  (afull),
    .almost_empty (aempty)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] q[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    logic        sv, mr, acc, pop;
    int          msz, mmem;

    rst = 1'b1; flush = 1'b0;
    s_bus.valid = 1'b0; s_bus.data = '0; m_bus.ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_m_valid", m_bus.valid, 0);
    chk("rst_m_data",  m_bus.data,  0);
    chk("rst_level",   level,       0);
    chk("rst_afull",   afull,       0);
    chk("rst_aempty",  aempty,      1);
    chk("rst_s_ready", s_bus.ready, 1);

    // single push, output held
    s_bus.valid = 1'b1; s_bus.data = 32'hA5A5_0001;
    tick();
    s_bus.valid = 1'b0;
    $display("push %h", 32'hA5A5_0001);
    #1;
    chk("p1_m_valid", m_bus.valid, 1);
    chk("p1_m_data",  m_bus.data,  32'hA5A5_0001);
    chk("p1_level",   level,       1);
    chk("p1_aempty",  aempty,      1);
    chk("p1_afull",   afull,       0);

    // fill to capacity DEPTH+1
    for (int i = 1; i <= 4; i++) begin
      s_bus.valid = 1'b1; s_bus.data = 32'hA5A5_0001 + i;
      tick();
      $display("push %h", 32'hA5A5_0001 + i);
      chk("fill_level", level, i + 1);
    end
    s_bus.valid = 1'b0;
    #1;
    chk("full_s_ready", s_bus.ready, 0);
    chk("full_level",   level,       5);
    chk("full_afull",   afull,       1);
    chk("full_aempty",  aempty,      0);

    m_bus.ready = 1'b1;
    chk("full_pop_data", m_bus.data, 32'hA5A5_0001);
    tick();
    m_bus.ready = 1'b0;
    $display("pop  %h", 32'hA5A5_0001);
    #1;
    chk("after_pop_s_ready", s_bus.ready, 1);
    chk("after_pop_level",   level,       4);
    chk("after_pop_data",    m_bus.data,  32'hA5A5_0002);
    chk("after_pop_afull",   afull,       1);

    m_bus.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", m_bus.data, 32'hA5A5_0001 + i);
      tick();
      $display("pop  %h", 32'hA5A5_0001 + i);
    end
    m_bus.ready = 1'b0;
    #1;
    chk("drain_m_valid", m_bus.valid, 0);
    chk("drain_level",   level,       0);

    // full-throughput streaming
    s_bus.valid = 1'b1; m_bus.ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s_bus.data = 32'h1000_0000 + i;
      tick();
      chk("stream_m_valid", m_bus.valid, 1);
      chk("stream_m_data",  m_bus.data,  32'h1000_0000 + i);
      chk("stream_level",   level,       1);
      chk("stream_s_ready", s_bus.ready, 1);
    end
    $display("stream 100 words done");
    s_bus.valid = 1'b0;
    tick();
    m_bus.ready = 1'b0;
    chk("stream_end_level", level, 0);

    // randomised traffic against a queue model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      sv = 1'($urandom_range(0, 1));
      mr = 1'($urandom_range(0, 1));
      d  = $urandom;
      s_bus.valid = sv; s_bus.data = d; m_bus.ready = mr;
      #1;
      msz  = q.size();
      mmem = (msz > 0) ? msz - 1 : 0;
      chk("rnd_s_ready", s_bus.ready, (mmem != DEPTH) ? 1 : 0);
      chk("rnd_m_valid", m_bus.valid, (msz > 0) ? 1 : 0);
      if (msz > 0) chk("rnd_m_data", m_bus.data, q[0]);
      acc = sv && (mmem != DEPTH);
      pop = mr && (msz > 0);
      tick();
      if (pop) void'(q.pop_front());
      if (acc) q.push_back(d);
      chk("rnd_level",  level,  q.size());
      chk("rnd_afull",  afull,  (q.size() >= 4) ? 1 : 0);
      chk("rnd_aempty", aempty, (q.size() <= 1) ? 1 : 0);
    end
    $display("random 10000 cycles done");
    s_bus.valid = 1'b0; m_bus.ready = 1'b1;
    repeat (6) tick();
    m_bus.ready = 1'b0;
    q.delete();
    chk("rnd_drain_level", level, 0);

    // flush together with a pop at level 3
    for (int i = 0; i < 3; i++) begin
      s_bus.valid = 1'b1; s_bus.data = 32'hB000_0000 + i;
      tick();
      $display("push %h", 32'hB000_0000 + i);
    end
    s_bus.valid = 1'b0;
    chk("pre_flush_level", level, 3);
    flush = 1'b1; m_bus.ready = 1'b1;
    #1;
    chk("flush_s_ready",  s_bus.ready, 0);
    chk("flush_m_valid",  m_bus.valid, 1);
    chk("flush_pop_data", m_bus.data,  32'hB000_0000);
    tick();
    flush = 1'b0; m_bus.ready = 1'b0;
    $display("flush with pop %h", 32'hB000_0000);
    #1;
    chk("post_flush_level",   level,       0);
    chk("post_flush_m_valid", m_bus.valid, 0);
    chk("post_flush_aempty",  aempty,      1);
    chk("post_flush_afull",   afull,       0);
    chk("post_flush_s_ready", s_bus.ready, 1);
    s_bus.valid = 1'b1; s_bus.data = 32'hC000_0000;
    tick();
    s_bus.valid = 1'b0;
    $display("push %h", 32'hC000_0000);
    chk("post_flush_push_valid", m_bus.valid, 1);
    chk("post_flush_push_data",  m_bus.data,  32'hC000_0000);
    chk("post_flush_push_level", level,       1);

    // asynchronous reset between edges at level 4
    for (int i = 1; i <= 3; i++) begin
      s_bus.valid = 1'b1; s_bus.data = 32'hC000_0000 + i;
      tick();
      $display("push %h", 32'hC000_0000 + i);
    end
    s_bus.valid = 1'b0;
    chk("pre_rst_level", level, 4);
    #2 rst = 1'b1;
    #1;
    chk("arst_m_valid", m_bus.valid, 0);
    chk("arst_m_data",  m_bus.data,  0);
    chk("arst_level",   level,       0);
    chk("arst_afull",   afull,       0);
    chk("arst_aempty",  aempty,      1);
    $display("async reset applied");
    tick();
    rst = 1'b0;
    #1;
    chk("arst_s_ready", s_bus.ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
